// File: rtl/hazard_detect_unit.sv
// Load-use hazard detection and multi-cycle DIV/REM stall sequencing for the EX stage.
// Optional stall performance counters are built when HAZ_PERF_CNT_EN is defined.
module hazard_detect_unit #(
  parameter int DIV_LATENCY = 4,
  parameter int REG_ADDR_W  = 5
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  IDEX_MEM_READ,
  input  logic [REG_ADDR_W-1:0] IDEX_RD_ADDR,
  input  logic [REG_ADDR_W-1:0] IFID_RS1_ADDR,
  input  logic [REG_ADDR_W-1:0] IFID_RS2_ADDR,
  input  logic                  IFID_RS1_USED,
  input  logic                  IFID_RS2_USED,
  input  logic                  IDEX_DIV_START,
  input  logic                  BRANCH_SEL,
  output logic                  LU_HAZ_SIGNAL,
  output logic                  MD_STALL,
  output logic                  EXMEM_BUBBLE,
  output logic                  DIV_DONE
`ifdef HAZ_PERF_CNT_EN
  ,
  output logic [31:0]           LU_STALL_CNT,
  output logic [31:0]           DIV_STALL_CNT
`endif
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_FIN  = 2'd2
  } state_t;

  // Busy cycles after the start cycle; the start cycle itself is also frozen.
  localparam logic [4:0] DIV_LOAD = 5'(DIV_LATENCY - 2);

  state_t     state, state_next;
  logic [4:0] count, count_next;
  logic       raw_hazard;
  logic       div_start_now;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state <= IDLE;
      count <= 5'd0;
    end else begin
      state <= state_next;
      count <= count_next;
    end
  end

  assign raw_hazard = IDEX_MEM_READ && (IDEX_RD_ADDR != '0) &&
                      ((IFID_RS1_USED && (IFID_RS1_ADDR == IDEX_RD_ADDR)) ||
                       (IFID_RS2_USED && (IFID_RS2_ADDR == IDEX_RD_ADDR)));

  // A taken branch wins over a div start so the flushed div never begins.
  assign div_start_now = RESET && (state == IDLE) && IDEX_DIV_START && !BRANCH_SEL;

  always_comb begin
    state_next    = state;
    count_next    = count;
    LU_HAZ_SIGNAL = 1'b0;
    MD_STALL      = 1'b0;
    EXMEM_BUBBLE  = 1'b0;
    DIV_DONE      = 1'b0;

    case (state)
      IDLE: begin
        if (div_start_now) begin
          count_next = DIV_LOAD;
          state_next = (DIV_LOAD == 5'd0) ? DIV_FIN : DIV_BUSY;
        end
      end
      DIV_BUSY: begin
        // Leave on the cycle the counter reaches zero so the freeze lasts DIV_LATENCY-1 cycles.
        count_next = (count == 5'd0) ? 5'd0 : count - 5'd1;
        if (count <= 5'd1) state_next = DIV_FIN;
      end
      DIV_FIN: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
        count_next = 5'd0;
      end
    endcase

    if (RESET) begin
      MD_STALL      = div_start_now || (state == DIV_BUSY);
      EXMEM_BUBBLE  = div_start_now || (state == DIV_BUSY);
      DIV_DONE      = (state == DIV_FIN);
      LU_HAZ_SIGNAL = raw_hazard && ((state == IDLE) || (state == DIV_FIN)) &&
                      !BRANCH_SEL && !div_start_now;
    end
  end

`ifdef HAZ_PERF_CNT_EN
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      LU_STALL_CNT  <= 32'd0;
      DIV_STALL_CNT <= 32'd0;
    end else begin
      if (LU_HAZ_SIGNAL) LU_STALL_CNT  <= LU_STALL_CNT + 32'd1;
      if (MD_STALL)      DIV_STALL_CNT <= DIV_STALL_CNT + 32'd1;
    end
  end
`endif

endmodule

// File: doc/hazard_detect_unit.md
Name: hazard_detect_unit

Overview:
- Producer side of the hazard/flush interface in the pipelined RV32IM core.
- Detects load-use hazards between the ID and EX stages and drives LU_HAZ_SIGNAL into the flush unit.
- Sequences multi-cycle DIV/REM stalls in EX with a counter-based FSM.
- Drives a freeze signal for PC, IF/ID and ID/EX, and a bubble request for EX/MEM.

Parameters:
- DIV_LATENCY, 4: number of cycles a DIV/DIVU/REM/REMU occupies EX. Legal range 2..31.
- REG_ADDR_W, 5: register address width.

Ports:
- CLK  input  1  core clock, rising-edge.
- RESET  input  1  asynchronous, active-low reset.
- IDEX_MEM_READ  input  1  instruction in EX is a load.
- IDEX_RD_ADDR  input  REG_ADDR_W  destination register of the EX instruction.
- IFID_RS1_ADDR  input  REG_ADDR_W  rs1 of the ID instruction.
- IFID_RS2_ADDR  input  REG_ADDR_W  rs2 of the ID instruction.
- IFID_RS1_USED  input  1  ID instruction reads rs1.
- IFID_RS2_USED  input  1  ID instruction reads rs2.
- IDEX_DIV_START  input  1  EX instruction is a div/rem; sampled only in IDLE.
- BRANCH_SEL  input  1  taken branch/jump resolved in EX this cycle.
- LU_HAZ_SIGNAL  output  1  load-use hazard; goes to the flush unit.
- MD_STALL  output  1  freeze PC, IF/ID and ID/EX.
- EXMEM_BUBBLE  output  1  write a NOP into EX/MEM this cycle.
- DIV_DONE  output  1  one-cycle pulse; divider result is valid in EX.

Behaviour:
- Reset (RESET=0, async):
  - state = IDLE, counter = 0.
  - All outputs = 0; LU_HAZ_SIGNAL is forced 0 while RESET is low.
- Load-use detection (combinational):
  - raw = IDEX_MEM_READ && IDEX_RD_ADDR != 0 && ((IFID_RS1_USED && IFID_RS1_ADDR == IDEX_RD_ADDR) || (IFID_RS2_USED && IFID_RS2_ADDR == IDEX_RD_ADDR)).
  - LU_HAZ_SIGNAL = raw && state == IDLE && !BRANCH_SEL && !div_start_now.
  - BRANCH_SEL suppresses it: the ID instruction is flushed, so no stall is needed.
  - Exactly one bubble per load. The next cycle the load is in MEM, raw falls naturally, and the unit adds no extra state.
- States: IDLE, DIV_BUSY, DIV_FIN.
- IDLE:
  - If IDEX_DIV_START && !BRANCH_SEL: load counter = DIV_LATENCY-2, go to DIV_BUSY.
  - MD_STALL and EXMEM_BUBBLE assert combinationally in the same cycle (div_start_now).
  - BRANCH_SEL && IDEX_DIV_START is illegal by decode. The unit gives branch priority and stays in IDLE.
- DIV_BUSY:
  - MD_STALL = 1, EXMEM_BUBBLE = 1, LU_HAZ_SIGNAL = 0.
  - IDEX_DIV_START and BRANCH_SEL are ignored.
  - counter decrements each cycle; at counter == 0, go to DIV_FIN.
- DIV_FIN (one cycle):
  - DIV_DONE = 1, MD_STALL = 0, EXMEM_BUBBLE = 0.
  - The div result advances into EX/MEM and the pipeline resumes.
  - Load-use detection is live again in this cycle; LU_HAZ_SIGNAL follows the IDLE equation using the current inputs.
  - The next state is IDLE. The same instruction's IDEX_DIV_START has moved on, so it is not restarted.
- Total stall: DIV_LATENCY-1 frozen cycles, then DIV_FIN.
- Back-to-back divs: a second div reaching EX in the cycle after DIV_FIN restarts the sequence from IDLE.
- Mid-operation reset aborts to IDLE immediately. DIV_DONE is never emitted for the aborted op.
- Counter width is 5 bits; it never wraps because it stops at 0.

Optional Feature:
- Macro: HAZ_PERF_CNT_EN.
- Defined:
  - Adds outputs LU_STALL_CNT[31:0] and DIV_STALL_CNT[31:0].
  - LU_STALL_CNT increments on every cycle with LU_HAZ_SIGNAL = 1.
  - DIV_STALL_CNT increments on every cycle with MD_STALL = 1.
  - Both wrap at 2^32, saturate never, and clear to 0 on reset.
- Undefined: the ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Load-use hit: IDEX_MEM_READ=1, IDEX_RD_ADDR=5, IFID_RS2_ADDR=5, RS2_USED=1 -> LU_HAZ_SIGNAL=1 for exactly that cycle. The next cycle, with IDEX_MEM_READ=0, gives 0.
- x0 and unused operand: the same setup with RD=0 gives LU_HAZ_SIGNAL=0. RD=7 matching RS1 with RS1_USED=0 also gives 0.
- Branch suppression: a load-use hit while BRANCH_SEL=1 -> LU_HAZ_SIGNAL=0.
- Divide, DIV_LATENCY=4: IDEX_DIV_START pulse at cycle t ->
  - MD_STALL=1 at t, t+1, t+2;
  - DIV_DONE=1 and MD_STALL=0 at t+3;
  - state returns to IDLE at t+4.
  - A load-use hit presented at t+1 gives LU_HAZ_SIGNAL=0.
- Reset mid-divide: assert RESET=0 at t+1 -> MD_STALL, EXMEM_BUBBLE and DIV_DONE all 0 asynchronously. After release, no DIV_DONE appears.
- With HAZ_PERF_CNT_EN: two load-use stalls plus one DIV_LATENCY=4 divide -> LU_STALL_CNT=2, DIV_STALL_CNT=3.
